// File: rtl/add_fp64_arb_if.sv
// rtl/add_fp64_arb_if.sv - request, add_fp64 and response signal bundle for add_fp64_arb
interface add_fp64_arb_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_rm;
    logic [63:0] req0_src1;
    logic [63:0] req0_src2;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_rm;
    logic [63:0] req1_src1;
    logic [63:0] req1_src2;
    logic        fpu_en;
    logic [2:0]  fpu_rm;
    logic [63:0] fpu_src1;
    logic [63:0] fpu_src2;
    logic [63:0] fpu_result;
    logic        fpu_nv;
    logic        fpu_of;
    logic        rsp0_valid;
    logic [63:0] rsp0_result;
    logic        rsp0_nv;
    logic        rsp0_of;
    logic        rsp1_valid;
    logic [63:0] rsp1_result;
    logic        rsp1_nv;
    logic        rsp1_of;
    logic [2:0]  inflight;

    // arbiter side
    modport slave (
        input  req0_valid, req0_rm, req0_src1, req0_src2,
        input  req1_valid, req1_rm, req1_src1, req1_src2,
        input  fpu_result, fpu_nv, fpu_of,
        output req0_ready, req1_ready,
        output fpu_en, fpu_rm, fpu_src1, fpu_src2,
        output rsp0_valid, rsp0_result, rsp0_nv, rsp0_of,
        output rsp1_valid, rsp1_result, rsp1_nv, rsp1_of,
        output inflight
    );

    // requester / add_fp64 side
    modport master (
        output req0_valid, req0_rm, req0_src1, req0_src2,
        output req1_valid, req1_rm, req1_src1, req1_src2,
        output fpu_result, fpu_nv, fpu_of,
        input  req0_ready, req1_ready,
        input  fpu_en, fpu_rm, fpu_src1, fpu_src2,
        input  rsp0_valid, rsp0_result, rsp0_nv, rsp0_of,
        input  rsp1_valid, rsp1_result, rsp1_nv, rsp1_of,
        input  inflight
    );
endinterface

// File: rtl/add_fp64_arb.sv
// rtl/add_fp64_arb.sv - two-requester arbiter for a pipelined add_fp64 (ADD_FP64_ARB_FIXED_PRIO_EN selects fixed priority)
module add_fp64_arb #(
    parameter int LATENCY = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    add_fp64_arb_if.slave bus
);

    logic               grant0;
    logic               grant1;
    logic               issue;
    logic [LATENCY-1:0] tag_valid;
    logic [LATENCY-1:0] tag_id;
    logic               ret;
    logic               ret_id;
    logic [2:0]         count;

`ifdef ADD_FP64_ARB_FIXED_PRIO_EN
    // requester 0 always wins a conflict
    always_comb begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid & ~bus.req0_valid;
    end
`else
    // prio holds the requester preferred on the next conflict; after a grant
    // the other requester becomes preferred, so reset (0) favours requester 0
    logic prio;

    // round-robin grant: a lone requester wins regardless of prio
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | ~prio);
        grant1 = bus.req1_valid & (~bus.req0_valid | prio);
    end

    // move preference away from whoever was just granted
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (grant0) begin
            prio <= 1'b1;
        end else if (grant1) begin
            prio <= 1'b0;
        end
    end
`endif

    assign issue  = grant0 | grant1;
    assign ret    = tag_valid[LATENCY-1];
    assign ret_id = tag_id[LATENCY-1];

    // handshake and add_fp64 drive; held quiet while reset is asserted
    always_comb begin
        bus.req0_ready = grant0 & reset_n;
        bus.req1_ready = grant1 & reset_n;
        bus.fpu_en     = issue & reset_n;
        bus.fpu_rm     = '0;
        bus.fpu_src1   = '0;
        bus.fpu_src2   = '0;
        if (reset_n && grant0) begin
            bus.fpu_rm   = bus.req0_rm;
            bus.fpu_src1 = bus.req0_src1;
            bus.fpu_src2 = bus.req0_src2;
        end else if (reset_n && grant1) begin
            bus.fpu_rm   = bus.req1_rm;
            bus.fpu_src1 = bus.req1_src1;
            bus.fpu_src2 = bus.req1_src2;
        end
    end

    // tag pipeline tracking which requester owns each add_fp64 stage
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_id    <= '0;
        end else begin
            tag_valid[0] <= issue;
            tag_id[0]    <= grant1;
            for (int i = 1; i < LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    // steer the returning add_fp64 result to its owner, zero elsewhere
    always_comb begin
        bus.rsp0_valid  = 1'b0;
        bus.rsp0_result = '0;
        bus.rsp0_nv     = 1'b0;
        bus.rsp0_of     = 1'b0;
        bus.rsp1_valid  = 1'b0;
        bus.rsp1_result = '0;
        bus.rsp1_nv     = 1'b0;
        bus.rsp1_of     = 1'b0;
        if (ret && !ret_id) begin
            bus.rsp0_valid  = 1'b1;
            bus.rsp0_result = bus.fpu_result;
            bus.rsp0_nv     = bus.fpu_nv;
            bus.rsp0_of     = bus.fpu_of;
        end else if (ret && ret_id) begin
            bus.rsp1_valid  = 1'b1;
            bus.rsp1_result = bus.fpu_result;
            bus.rsp1_nv     = bus.fpu_nv;
            bus.rsp1_of     = bus.fpu_of;
        end
    end

    // outstanding-operation count; issue and return together cancel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign bus.inflight = count;

endmodule

// File: tb/tb_add_fp64_arb.sv
// tb/tb_add_fp64_arb.sv - scoreboard bench for add_fp64_arb with a behavioural add_fp64
module tb_add_fp64_arb;

    localparam int LAT = 4;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        nv;
        logic        of;
        int          cyc;
    } sb_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;
    sb_t  sb[$];
    logic grant_log[$];
    logic prio_m;
    int   n_rsp0;
    int   n_rsp1;
    int   peak;
    logic [63:0] last0_res;
    logic        last0_nv;
    logic        last0_of;
    logic [63:0] last1_res;
    logic        last1_nv;
    logic [65:0] fpu_pipe [LAT];

    add_fp64_arb_if bus ();

    add_fp64_arb #(.LATENCY(LAT)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic is_inf(input logic [63:0] x);
        return (x[62:52] == 11'h7ff) && (x[51:0] == '0);
    endfunction

    function automatic logic is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7ff) && (x[51:0] != '0);
    endfunction

    // behavioural add_fp64: {result, nv, of}
    function automatic logic [65:0] fp_add(input logic [63:0] a, input logic [63:0] b);
        real         r;
        logic [63:0] res;
        logic        nv;
        logic        of;
        r   = $bitstoreal(a) + $bitstoreal(b);
        res = $realtobits(r);
        nv  = (is_inf(a) && is_inf(b) && (a[63] != b[63])) ||
              (is_nan(a) && !a[51]) || (is_nan(b) && !b[51]);
        of  = is_inf(res) && !is_inf(a) && !is_inf(b) && !is_nan(a) && !is_nan(b);
        return {res, nv, of};
    endfunction

    // add_fp64 pipeline: result appears LAT cycles after the d0 drive
    always @(posedge clk) begin
        fpu_pipe[0] <= bus.fpu_en ? fp_add(bus.fpu_src1, bus.fpu_src2) : 66'd0;
        for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
    end
    assign bus.fpu_result = fpu_pipe[LAT-1][65:2];
    assign bus.fpu_nv     = fpu_pipe[LAT-1][1];
    assign bus.fpu_of     = fpu_pipe[LAT-1][0];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // per-cycle monitor: grant model, d0 drive, in-order response scoreboard
    always @(negedge clk) begin : monitor
        logic        eg0;
        logic        eg1;
        logic        due;
        logic [63:0] es1;
        logic [63:0] es2;
        logic [2:0]  erm;
        logic [65:0] r;
        sb_t         e;
        if (!rst_n) begin
            check("rst_ready0", bus.req0_ready, 0);
            check("rst_ready1", bus.req1_ready, 0);
            check("rst_fpu_en", bus.fpu_en, 0);
            check("rst_fpu_src1", bus.fpu_src1, 0);
            check("rst_rsp0_valid", bus.rsp0_valid, 0);
            check("rst_rsp1_valid", bus.rsp1_valid, 0);
            check("rst_rsp0_result", bus.rsp0_result, 0);
            check("rst_inflight", bus.inflight, 0);
            sb.delete();
            prio_m = 1'b0;
        end else begin
`ifdef ADD_FP64_ARB_FIXED_PRIO_EN
            eg0 = bus.req0_valid;
`else
            eg0 = bus.req0_valid && (!bus.req1_valid || !prio_m);
`endif
            eg1 = bus.req1_valid && !eg0;
            check("ready0", bus.req0_ready, eg0);
            check("ready1", bus.req1_ready, eg1);
            check("inflight", bus.inflight, sb.size());
            if (bus.inflight > peak) peak = bus.inflight;
            es1 = eg0 ? bus.req0_src1 : eg1 ? bus.req1_src1 : 64'd0;
            es2 = eg0 ? bus.req0_src2 : eg1 ? bus.req1_src2 : 64'd0;
            erm = eg0 ? bus.req0_rm   : eg1 ? bus.req1_rm   : 3'd0;
            check("fpu_en", bus.fpu_en, eg0 | eg1);
            check("fpu_src1", bus.fpu_src1, es1);
            check("fpu_src2", bus.fpu_src2, es2);
            check("fpu_rm", bus.fpu_rm, erm);

            due = (sb.size() > 0) && (sb[0].cyc + LAT == cyc);
            check("rsp0_valid", bus.rsp0_valid, due && !sb[0].id);
            check("rsp1_valid", bus.rsp1_valid, due && sb[0].id);
            if (due) begin
                e = sb.pop_front();
                if (!e.id) begin
                    check("rsp0_result", bus.rsp0_result, e.res);
                    check("rsp0_nv", bus.rsp0_nv, e.nv);
                    check("rsp0_of", bus.rsp0_of, e.of);
                    check("rsp1_idle_result", bus.rsp1_result, 0);
                end else begin
                    check("rsp1_result", bus.rsp1_result, e.res);
                    check("rsp1_nv", bus.rsp1_nv, e.nv);
                    check("rsp1_of", bus.rsp1_of, e.of);
                    check("rsp0_idle_result", bus.rsp0_result, 0);
                end
            end else begin
                check("rsp0_idle_result", bus.rsp0_result, 0);
                check("rsp1_idle_result", bus.rsp1_result, 0);
                check("rsp_idle_flags", {bus.rsp0_nv, bus.rsp0_of, bus.rsp1_nv, bus.rsp1_of}, 0);
            end
            if (bus.rsp0_valid) begin
                n_rsp0++;
                last0_res = bus.rsp0_result;
                last0_nv  = bus.rsp0_nv;
                last0_of  = bus.rsp0_of;
            end
            if (bus.rsp1_valid) begin
                n_rsp1++;
                last1_res = bus.rsp1_result;
                last1_nv  = bus.rsp1_nv;
            end
            if (bus.req0_ready || bus.req1_ready) grant_log.push_back(bus.req1_ready);

            if (eg0 || eg1) begin
                r = fp_add(es1, es2);
                sb.push_back('{id: eg1, res: r[65:2], nv: r[1], of: r[0], cyc: cyc});
                prio_m = eg0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        tick(n);
        rst_n = 1'b1;
    endtask

    task automatic drive(input int idx, input logic v, input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm);
        if (idx == 0) begin
            bus.req0_valid = v; bus.req0_src1 = a; bus.req0_src2 = b; bus.req0_rm = rm;
        end else begin
            bus.req1_valid = v; bus.req1_src1 = a; bus.req1_src2 = b; bus.req1_rm = rm;
        end
    endtask

    function automatic logic [63:0] rnd64();
        logic [63:0] x;
        x = {$urandom(), $urandom()};
        x[62] = 1'b0;
        return x;
    endfunction

    initial begin : stim
        int   base0;
        int   base1;
        int   total;
        logic exp_id;
        cyc = 0; n_cmp = 0; n_err = 0; n_rsp0 = 0; n_rsp1 = 0; peak = 0;
        prio_m = 1'b0;
        last0_res = '0; last0_nv = 1'b0; last0_of = 1'b0; last1_res = '0; last1_nv = 1'b0;
        rst_n = 1'b0;
        drive(0, 1'b1, 64'h3ff0000000000000, 64'h3ff0000000000000, 3'd0);
        drive(1, 1'b1, 64'h4000000000000000, 64'h4000000000000000, 3'd0);
        tick(3);
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        rst_n = 1'b1;
        tick(1);

        // single request on req0: 1.0 + 2.0
        base0 = n_rsp0;
        drive(0, 1'b1, 64'h3ff0000000000000, 64'h4000000000000000, 3'd0);
        tick(1);
        drive(0, 1'b0, 0, 0, 0);
        tick(6);
        check("t028_rsp_count", n_rsp0 - base0, 1);
        check("t028_result", last0_res, 64'h4008000000000000);
        check("t028_nv_of", {last0_nv, last0_of}, 2'b00);

        // both requesters valid for 8 cycles right after reset
        do_reset(2);
        grant_log.delete();
        peak = 0;
        base0 = n_rsp0; base1 = n_rsp1;
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, rnd64(), rnd64(), 3'd0);
            drive(1, 1'b1, rnd64(), rnd64(), 3'd0);
            tick(1);
        end
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        tick(6);
        check("t029_grants", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef ADD_FP64_ARB_FIXED_PRIO_EN
            exp_id = 1'b0;
`else
            exp_id = i[0];
`endif
            check($sformatf("t029_grant%0d", i), grant_log[i], exp_id);
        end
`ifdef ADD_FP64_ARB_FIXED_PRIO_EN
        check("t032_rsp0_count", n_rsp0 - base0, 8);
        check("t032_rsp1_count", n_rsp1 - base1, 0);
`else
        check("t029_rsp0_count", n_rsp0 - base0, 4);
        check("t029_rsp1_count", n_rsp1 - base1, 4);
`endif
        check("t029_peak", peak, 4);

        // +Inf + -Inf on req1
        base0 = n_rsp0; base1 = n_rsp1;
        drive(1, 1'b1, 64'h7ff0000000000000, 64'hfff0000000000000, 3'd0);
        tick(1);
        drive(1, 1'b0, 0, 0, 0);
        tick(6);
        check("t030_rsp1_count", n_rsp1 - base1, 1);
        check("t030_is_nan", is_nan(last1_res), 1);
        check("t030_nv", last1_nv, 1);
        check("t030_rsp0_quiet", n_rsp0 - base0, 0);

        // reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, rnd64(), rnd64(), 3'(i));
            tick(1);
        end
        total = n_rsp0 + n_rsp1;
        do_reset(2);
        drive(0, 1'b0, 0, 0, 0);
        check("t031_inflight", bus.inflight, 0);
        tick(8);
        check("t031_no_rsp", n_rsp0 + n_rsp1 - total, 0);
        check("t031_inflight_late", bus.inflight, 0);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            drive(0, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 3'($urandom_range(0, 4)));
            drive(1, 1'($urandom_range(0, 1)), rnd64(), rnd64(), 3'($urandom_range(0, 4)));
            tick(1);
        end
        drive(0, 1'b0, 0, 0, 0);
        drive(1, 1'b0, 0, 0, 0);
        tick(LAT + 2);
        check("drain_empty", sb.size(), 0);
        check("drain_inflight", bus.inflight, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
